// File: rtl/vio_pok_filter_pkg.sv
// Shared types and default debounce constants for the VIO power-good filter.
// The defaults are also used by the pwrmgr integration.
package vio_pok_filter_pkg;

   typedef enum logic [1:0] {
      ST_OFF       = 2'b00,
      ST_RISE_WAIT = 2'b01,
      ST_ON        = 2'b10,
      ST_FALL_WAIT = 2'b11
   } vio_pok_state_e;

   localparam int unsigned VioPokSyncStages = 2;
   localparam int unsigned VioPokRiseCnt    = 16;
   localparam int unsigned VioPokFallCnt    = 2;
   localparam int unsigned VioPokGlitchCntW = 8;

   // True when the state reports power as good.
   function automatic logic pok_level(input vio_pok_state_e st);
      return (st == ST_ON) || (st == ST_FALL_WAIT);
   endfunction

endpackage

// File: rtl/vio_pok_sync.sv
// N-stage synchronizer for the raw power-good flag.
// It lives in its own module so that CDC tooling can waive one instance.
module vio_pok_sync
   import vio_pok_filter_pkg::*;
#(
   parameter int unsigned Stages = VioPokSyncStages
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[Stages-2:0], d_i};
      end
   end

   assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/vio_pok_filter.sv
// Debounces the synchronized VIO power-good flag with separate rise and fall windows.
// It also reports aborted windows as glitches and counts them.
module vio_pok_filter
   import vio_pok_filter_pkg::*;
#(
   parameter int unsigned SyncStages = VioPokSyncStages,
   parameter int unsigned RiseCnt    = VioPokRiseCnt,
   parameter int unsigned FallCnt    = VioPokFallCnt,
   parameter int unsigned GlitchCntW = VioPokGlitchCntW
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  vio_pok_i,
   output logic                  vio_pok_o,
   output logic                  vio_pok_rise_o,
   output logic                  vio_pok_fall_o,
   output logic                  glitch_o,
   output logic [GlitchCntW-1:0] glitch_cnt_o,
   input  logic                  glitch_clr_i
);

   localparam int unsigned CntMax = (RiseCnt > FallCnt) ? RiseCnt : FallCnt;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] RiseLast = CntW'(RiseCnt - 1);
   localparam logic [CntW-1:0] FallLast = CntW'(FallCnt - 1);

   logic                  pok_s;
   vio_pok_state_e        state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  pok_q, pok_d;
   logic                  rise_q, rise_d;
   logic                  fall_q, fall_d;
   logic                  glitch_q, glitch_d;
   logic [GlitchCntW-1:0] glitch_cnt_q, glitch_cnt_d;

   vio_pok_sync #(
      .Stages (SyncStages)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (vio_pok_i),
      .q_o   (pok_s)
   );

   // Next-state, debounce count and event pulses.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = 1'b0;

      unique case (state_q)
         ST_OFF: begin
            if (pok_s) begin
               state_d = ST_RISE_WAIT;
            end
         end
         ST_RISE_WAIT: begin
            if (!pok_s) begin
               state_d  = ST_OFF;
               glitch_d = 1'b1;
            end else if (cnt_q == RiseLast) begin
               state_d = ST_ON;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         ST_ON: begin
            if (!pok_s) begin
               state_d = ST_FALL_WAIT;
            end
         end
         ST_FALL_WAIT: begin
            if (pok_s) begin
               state_d  = ST_ON;
               glitch_d = 1'b1;
            end else if (cnt_q == FallLast) begin
               state_d = ST_OFF;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase

      // Every window starts from zero.
      if (state_d != state_q) begin
         cnt_d = '0;
      end

      pok_d = pok_level(state_d);
   end

   // Saturating glitch count; a clear coinciding with a glitch keeps that glitch.
   always_comb begin
      glitch_cnt_d = glitch_cnt_q;
      if (glitch_clr_i) begin
         glitch_cnt_d = glitch_d ? GlitchCntW'(1) : '0;
      end else if (glitch_d && !(&glitch_cnt_q)) begin
         glitch_cnt_d = glitch_cnt_q + GlitchCntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_OFF;
         cnt_q        <= '0;
         pok_q        <= 1'b0;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         glitch_q     <= 1'b0;
         glitch_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pok_q        <= pok_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         glitch_q     <= glitch_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign vio_pok_o      = pok_q;
   assign vio_pok_rise_o = rise_q;
   assign vio_pok_fall_o = fall_q;
   assign glitch_o       = glitch_q;
   assign glitch_cnt_o   = glitch_cnt_q;

endmodule

// File: tb/tb_vio_pok_filter.sv
// Self-checking bench for vio_pok_filter: directed segment table, hand sequences
// for saturation and clear, then random stimulus against a run-length model.
module tb_vio_pok_filter;

   localparam int SYNC = 2;
   localparam int RISE = 16;
   localparam int FALL = 2;
   localparam int GMAX = 255;

   logic       clk;
   logic       rst;
   logic       pok_in;
   logic       clr;
   logic       pok_out;
   logic       rise;
   logic       fall;
   logic       glitch;
   logic [7:0] gcnt;

   int checks;
   int failures;

   vio_pok_filter dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .vio_pok_i      (pok_in),
      .vio_pok_o      (pok_out),
      .vio_pok_rise_o (rise),
      .vio_pok_fall_o (fall),
      .glitch_o       (glitch),
      .glitch_cnt_o   (gcnt),
      .glitch_clr_i   (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: output level plus a run length of synced samples that
   // disagree with it; a run reaching window+1 flips the level, a run broken early is a glitch.
   bit m_sync[SYNC];
   bit m_out, m_rise, m_fall, m_glitch;
   int m_run;
   int m_gcnt;

   task automatic model_edge();
      bit ps;
      bit g;
      if (rst) begin
         for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
         m_out = 0; m_rise = 0; m_fall = 0; m_glitch = 0; m_run = 0; m_gcnt = 0;
      end else begin
         ps = m_sync[SYNC-1];
         g = 1'b0;
         m_rise = 1'b0;
         m_fall = 1'b0;
         if (ps != m_out) begin
            m_run++;
            if (m_run == (m_out ? FALL : RISE) + 1) begin
               if (m_out) m_fall = 1'b1;
               else       m_rise = 1'b1;
               m_out = !m_out;
               m_run = 0;
            end
         end else if (m_run > 0) begin
            g = 1'b1;
            m_run = 0;
         end
         m_glitch = g;
         if (clr)                  m_gcnt = g ? 1 : 0;
         else if (g && m_gcnt < GMAX) m_gcnt++;
         for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
         m_sync[0] = pok_in;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit rst;
      bit pok;
      bit clr;
      int n;
      bit o;
      bit r;
      bit f;
      bit g;
      int gc;
   } vec_t;

   vec_t tbl[20];
   int   gl_seen;
   bit   dropped;

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      pok_in   = 1'b0;
      clr      = 1'b0;

      //          rst  pok  clr   n   o  r  f  g  gc
      tbl[0]  = '{1'b1,1'b0,1'b0, 2, 0, 0, 0, 0, 0};  // reset state
      tbl[1]  = '{1'b0,1'b1,1'b0,18, 0, 0, 0, 0, 0};  // edges 0..17 still qualifying
      tbl[2]  = '{1'b0,1'b1,1'b0, 1, 1, 1, 0, 0, 0};  // edge 18 asserts
      tbl[3]  = '{1'b0,1'b1,1'b0, 1, 1, 0, 0, 0, 0};  // rise is one cycle
      tbl[4]  = '{1'b0,1'b0,1'b0, 4, 1, 0, 0, 0, 0};  // edges 0..3
      tbl[5]  = '{1'b0,1'b0,1'b0, 1, 0, 0, 1, 0, 0};  // edge 4 deasserts
      tbl[6]  = '{1'b0,1'b0,1'b0, 1, 0, 0, 0, 0, 0};
      tbl[7]  = '{1'b0,1'b1,1'b0,10, 0, 0, 0, 0, 0};  // 10-cycle high pulse
      tbl[8]  = '{1'b0,1'b0,1'b0, 2, 0, 0, 0, 0, 0};
      tbl[9]  = '{1'b0,1'b0,1'b0, 1, 0, 0, 0, 1, 1};  // aborted rise window
      tbl[10] = '{1'b0,1'b0,1'b0, 1, 0, 0, 0, 0, 1};
      tbl[11] = '{1'b0,1'b1,1'b0,19, 1, 1, 0, 0, 1};
      tbl[12] = '{1'b0,1'b0,1'b0, 1, 1, 0, 0, 0, 1};  // 1-cycle low pulse
      tbl[13] = '{1'b0,1'b1,1'b0, 2, 1, 0, 0, 0, 1};
      tbl[14] = '{1'b0,1'b1,1'b0, 1, 1, 0, 0, 1, 2};  // aborted fall window
      tbl[15] = '{1'b0,1'b1,1'b0, 1, 1, 0, 0, 0, 2};
      tbl[16] = '{1'b0,1'b1,1'b1, 1, 1, 0, 0, 0, 0};  // clear alone
      tbl[17] = '{1'b1,1'b1,1'b0, 1, 0, 0, 0, 0, 0};  // reset in ON, no fall pulse
      tbl[18] = '{1'b0,1'b1,1'b0,18, 0, 0, 0, 0, 0};  // full re-qualification
      tbl[19] = '{1'b0,1'b1,1'b0, 1, 1, 1, 0, 0, 0};

      for (int i = 0; i < 20; i++) begin
         rst    = tbl[i].rst;
         pok_in = tbl[i].pok;
         clr    = tbl[i].clr;
         for (int k = 0; k < tbl[i].n; k++) step();
         chk($sformatf("vec%0d_pok", i),    int'(pok_out), int'(tbl[i].o));
         chk($sformatf("vec%0d_rise", i),   int'(rise),    int'(tbl[i].r));
         chk($sformatf("vec%0d_fall", i),   int'(fall),    int'(tbl[i].f));
         chk($sformatf("vec%0d_glitch", i), int'(glitch),  int'(tbl[i].g));
         chk($sformatf("vec%0d_gcnt", i),   int'(gcnt),    tbl[i].gc);
      end
      rst = 1'b0;
      clr = 1'b0;

      // 260 one-cycle low pulses from ON: counter saturates, pulses keep coming.
      gl_seen = 0;
      dropped = 1'b0;
      for (int i = 0; i < 260; i++) begin
         pok_in = 1'b0;
         step();
         if (glitch) gl_seen++;
         if (!pok_out) dropped = 1'b1;
         pok_in = 1'b1;
         for (int k = 0; k < 3; k++) begin
            step();
            if (glitch) gl_seen++;
            if (!pok_out) dropped = 1'b1;
         end
      end
      chk("sat_gcnt", int'(gcnt), GMAX);
      chk("sat_pulses", gl_seen, 260);
      chk("sat_pok_held", int'(dropped), 0);

      // Clear coinciding with a glitch leaves a count of one.
      pok_in = 1'b0;
      step();
      pok_in = 1'b1;
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_glitch_pulse", int'(glitch), 1);
      chk("clr_glitch_gcnt", int'(gcnt), 1);
      step();
      chk("clr_glitch_after", int'(gcnt), 1);

      // Random runs against the model.
      for (int c = 0; c < 3000; ) begin
         int len;
         pok_in = 1'($urandom_range(0, 1));
         len    = int'($urandom_range(1, 24));
         for (int k = 0; k < len; k++) begin
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
            chk("rnd_pok",    int'(pok_out), int'(m_out));
            chk("rnd_rise",   int'(rise),    int'(m_rise));
            chk("rnd_fall",   int'(fall),    int'(m_fall));
            chk("rnd_glitch", int'(glitch),  int'(m_glitch));
            chk("rnd_gcnt",   int'(gcnt),    m_gcnt);
            c++;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
